// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between two requesters. Port 0 (CPU MEM
//   stage) has priority. Port 1 (DMA/loader) is protected from starvation by a
//   wait counter that force-grants it after MAX_WAIT consecutive refused cycles.
//   One access is issued per cycle. The response (read data + error flag)
//   appears one cycle after acceptance. Out-of-range and misaligned word stores
//   are rejected without writing memory.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake (ready is combinational)
//   reqN_we, reqN_byte           store enable, byte-lane store select
//   reqN_addr, reqN_wdata        byte address, store data
//   rspN_valid                   one-cycle response pulse per acceptance
//   rspN_rdata, rspN_err         pre-write word at the address (0 on error)
//   mem_we, mem_a, mem_wd, mem_b memory drive (all 0 when nothing is granted)
//   mem_rd                       combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic        req0_byte,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic        req1_byte,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_b,
  input  logic [31:0] mem_rd
);

  localparam logic [29:0] LP_DEPTH    = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_wait_cnt;
  logic        r_rsp0_valid;
  logic [31:0] r_rsp0_rdata;
  logic        r_rsp0_err;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp1_rdata;
  logic        r_rsp1_err;

  logic        w_force;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_we;
  logic        w_byte;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;

  // Grants are gated by reset_n so nothing is accepted or written while reset
  // is asserted, even in the middle of a cycle.
  assign w_force = (r_wait_cnt >= LP_MAX_WAIT);
  assign w_gnt1  = reset_n & req1_valid & (w_force | ~req0_valid);
  assign w_gnt0  = reset_n & req0_valid & ~w_gnt1;

  // Selected request; stays all-zero when nothing is granted so the memory
  // drive outputs fall to 0 without extra gating.
  always_comb begin
    w_we    = 1'b0;
    w_byte  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_gnt1) begin
      w_we    = req1_we;
      w_byte  = req1_byte;
      w_addr  = req1_addr;
      w_wdata = req1_wdata;
    end else if (w_gnt0) begin
      w_we    = req0_we;
      w_byte  = req0_byte;
      w_addr  = req0_addr;
      w_wdata = req0_wdata;
    end
  end

  // Loads ignore the low address bits; only word stores must be aligned.
  assign w_err = (w_addr[31:2] >= LP_DEPTH) |
                 (w_we & ~w_byte & (w_addr[1:0] != 2'b00));

  assign mem_we = w_we & ~w_err;
  assign mem_a  = w_addr;
  assign mem_wd = w_wdata;
  assign mem_b  = w_byte;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Response registers: valid pulses for each acceptance, data/err hold when
  // the port is not accepting. mem_rd is sampled before the write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
      r_rsp1_err   <= 1'b0;
    end else begin
      r_rsp0_valid <= w_gnt0;
      r_rsp1_valid <= w_gnt1;
      if (w_gnt0) begin
        r_rsp0_err   <= w_err;
        r_rsp0_rdata <= w_err ? '0 : mem_rd;
      end
      if (w_gnt1) begin
        r_rsp1_err   <= w_err;
        r_rsp1_rdata <= w_err ? '0 : mem_rd;
      end
    end
  end

  // Counts consecutive cycles port 1 is waiting; saturates so a long stall
  // can never wrap back below the force threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (req1_valid && !w_gnt1) begin
      if (r_wait_cnt != 4'hF) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp0_err   = r_rsp0_err;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_rdata = r_rsp1_rdata;
  assign rsp1_err   = r_rsp1_err;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU MEM stage and has priority, port 1 is the DMA/loader port.
- Valid/ready request handshake per port. Issues one memory access per cycle, with word or byte-lane store.
- Returns read data and an error flag one cycle after acceptance.
- Rejects out-of-range and misaligned accesses without touching memory.
- Anti-starvation counter guarantees port 1 progress under a continuous port 0 stream.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the data memory; word index range 0..DEPTH_WORDS-1.
- MAX_WAIT, 4, consecutive cycles port 1 may be valid and refused before it is force-granted; range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 request present.
- req0_ready  output  1  port 0 request accepted this cycle; combinational.
- req0_we  input  1  1=store, 0=load.
- req0_byte  input  1  store width: 1=byte lane selected by addr[1:0], 0=word.
- req0_addr  input  32  byte address.
- req0_wdata  input  32  store data; byte store takes the lane byte wdata[8*addr[1:0]+7 : 8*addr[1:0]].
- rsp0_valid  output  1  one-cycle pulse: response for the accepted port 0 request.
- rsp0_rdata  output  32  word read at the accepted address (loads and stores); 0 on error.
- rsp0_err  output  1  accepted request was rejected.
- req1_valid, req1_ready, req1_we, req1_byte, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_we  output  1  memory write enable.
- mem_a  output  32  memory byte address.
- mem_wd  output  32  memory write data.
- mem_b  output  1  memory byte-store select.
- mem_rd  input  32  memory combinational read data.

Behaviour:
- Grant is combinational each cycle:
  - If force is set and req1_valid, grant port 1.
  - Else if req0_valid, grant port 0.
  - Else if req1_valid, grant port 1.
  - Else no grant.
- force = (wait_cnt >= MAX_WAIT).
- reqN_ready = 1 only for the granted port, and only while reset_n=1. A handshake completes when valid&ready at the rising edge.
- Requesters must hold their request fields stable while valid and not ready. The arbiter does not buffer requests.
- Error rule for the granted request:
  - err = (addr[31:2] >= DEPTH_WORDS), OR
  - err = (we=1 AND byte=0 AND addr[1:0] != 0).
  - Loads ignore addr[1:0].
- Memory drive, granted cycle: mem_a=addr, mem_wd=wdata, mem_b=byte, mem_we = we & ~err & reset_n.
- Memory drive, no grant: all mem_* outputs 0.
- Response capture at the accepting edge:
  - rspN_valid <= 1.
  - rspN_err <= err.
  - rspN_rdata <= err ? 0 : mem_rd. This is pre-write data for stores.
- Response latency is exactly 1 cycle after acceptance. The response registers of a non-accepting port clear rspN_valid to 0 and hold rdata/err.
- Back-to-back acceptance on the same port every cycle is allowed; rsp valid stays high continuously in that case.
- wait_cnt, 4-bit:
  - Increments, saturating at 15, when req1_valid=1 and port 1 is not granted.
  - Clears to 0 when port 1 is granted or req1_valid=0.
- Reset (reset_n=0, asynchronous):
  - rsp0/1_valid=0, rsp0/1_rdata=0, rsp0/1_err=0, wait_cnt=0.
  - Both ready=0, mem_we=0.
  - A request in flight when reset asserts is dropped with no response.
  - The first grant is possible in the first cycle with reset_n=1.
- Simultaneous valid on both ports with force=0: port 0 wins. Port 1 waits, with wait_cnt counting, until force.

Test Plan:
- Port 0 word store addr=0x10, wdata=0xDEADBEEF; then load addr=0x10 -> store edge mem_we=1, mem_a=0x10; next-cycle load response rsp0_rdata=0xDEADBEEF, rsp0_err=0.
- Port 1 byte store addr=0x11, wdata=0x0000AB00 over word 0x11223344 -> mem_b=1; a later load of 0x10 returns 0x1122AB44.
- Port 0 load addr=0x100 (word 64 with DEPTH_WORDS=64), and word store addr=0x12 -> both: mem_we=0, rsp0_err=1, rsp0_rdata=0, memory unchanged.
- Both ports valid continuously, MAX_WAIT=4 -> port 0 granted cycles 0-3, port 1 granted cycle 4, pattern repeats; req1_ready pulses every 5th cycle.
- Assert reset_n=0 mid-cycle while port 0 store pending -> mem_we drops immediately, no write, rsp0_valid=0, wait_cnt=0; after release the request is accepted on the first cycle.
- Idle both ports -> all mem_* outputs 0, no rsp pulses, wait_cnt stays 0.
